operand_select_stage: RTL

OPERAND_SELECT_STAGE -- requirements
Module: operand_select_stage

---
 rtl/datapath_pkg.sv | 8 +
 rtl/opsel_entry_reg.sv | 40 ++++
 rtl/operand_select_stage.sv | 81 ++++++++
 3 files changed

// File: rtl/datapath_pkg.sv
// datapath_pkg: shared datapath width and operand-source index constants
package datapath_pkg;
  localparam int XLEN = 32;
  localparam int OPSEL_RS = 0;
  localparam int OPSEL_IMM = 1;
  localparam int OPSEL_FWD_MEM = 2;
  localparam int OPSEL_FWD_WB = 3;
endpackage

// File: rtl/opsel_entry_reg.sv
// opsel_entry_reg: one operand holding entry (data, sel_err, valid) with load and clear
// Ports: clock, reset_n (async active-low); load_i captures data_i/err_i and sets valid;
// clear_i (dominates load_i) empties the entry and zeroes data/err; data_o/err_o/valid_o are the held state.
module opsel_entry_reg
  import datapath_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             err_i,
  output logic [WIDTH-1:0] data_o,
  output logic             err_o,
  output logic             valid_o
);
  logic [WIDTH-1:0] data_q, data_d;
  logic err_q, err_d, valid_q, valid_d;
  always_comb begin
    data_d  = clear_i ? '0 : load_i ? data_i : data_q;
    err_d   = clear_i ? 1'b0 : load_i ? err_i : err_q;
    valid_d = clear_i ? 1'b0 : load_i ? 1'b1 : valid_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end
  assign data_o  = data_q;
  assign err_o   = err_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/operand_select_stage.sv
// operand_select_stage: registered operand mux with valid/ready handshake and flush
// Ports: clock, reset_n (async active-low); in_data/in_sel/in_valid/in_ready producer side;
// flush drops all held entries; out_data/out_valid/out_ready consumer side; sel_err marks an
// entry captured with in_sel >= NUM_IN (its data is zero).
// Macro OPSEL_SKID_EN adds a skid entry so in_ready comes straight from a flop.
module operand_select_stage
  import datapath_pkg::*;
#(
  parameter int WIDTH  = XLEN,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);
  logic [WIDTH-1:0] cap_data, head_in_data;
  logic cap_err, head_in_err, head_load, head_clear, ret, acc;
  always_comb begin
    cap_data = '0;
    for (int k = 0; k < NUM_IN; k++) cap_data = (in_sel == SEL_W'(k)) ? in_data[k*WIDTH +: WIDTH] : cap_data;
  end
  assign cap_err = int'(in_sel) >= NUM_IN;
`ifdef OPSEL_SKID_EN
  logic [WIDTH-1:0] skid_data;
  logic skid_err, skid_valid, skid_load, skid_clear;
  // A full skid blocks input; on retire the skid entry moves to head ahead of any new input.
  always_comb begin
    in_ready     = !skid_valid;
    ret          = out_valid && out_ready;
    acc          = in_valid && !skid_valid;
    head_load    = skid_valid ? ret : acc && (!out_valid || ret);
    head_clear   = flush || (ret && !head_load);
    skid_load    = acc && out_valid && !ret;
    skid_clear   = flush || (skid_valid && ret);
    head_in_data = skid_valid ? skid_data : cap_data;
    head_in_err  = skid_valid ? skid_err : cap_err;
  end
  opsel_entry_reg #(.WIDTH(WIDTH)) u_skid (
    .clock   (clock),
    .reset_n (reset_n),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .data_i  (cap_data),
    .err_i   (cap_err),
    .data_o  (skid_data),
    .err_o   (skid_err),
    .valid_o (skid_valid)
  );
`else
  always_comb begin
    in_ready     = !out_valid || out_ready;
    ret          = out_valid && out_ready;
    acc          = in_valid && in_ready;
    head_load    = acc;
    head_clear   = flush || (ret && !acc);
    head_in_data = cap_data;
    head_in_err  = cap_err;
  end
`endif
  // Clear dominates load, so anything accepted during flush is dropped.
  opsel_entry_reg #(.WIDTH(WIDTH)) u_head (
    .clock   (clock),
    .reset_n (reset_n),
    .load_i  (head_load),
    .clear_i (head_clear),
    .data_i  (head_in_data),
    .err_i   (head_in_err),
    .data_o  (out_data),
    .err_o   (sel_err),
    .valid_o (out_valid)
  );
endmodule
